// File: rtl/branch_pkg.sv
// Shared types for the branch unit.
// Contents: branch condition and FSM state encodings, flag bit positions, and a
// helper telling whether a condition depends on the compare flags.
package branch_pkg;

  typedef enum logic [1:0] {BR_AL, BR_LT, BR_GE, BR_NV} br_cond_t;

  typedef enum logic [1:0] {IDLE, WAIT_FLAGS, REDIRECT, FLUSH} br_state_t;

  localparam int unsigned FLAG_LT = 0;
  localparam int unsigned FLAG_GE = 1;

  // AL and NV resolve without looking at the comparator result.
  function automatic logic needs_flags(input br_cond_t cond);
    return (cond == BR_LT) || (cond == BR_GE);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluator.
// Ports:
//   cond   in   branch condition (AL/LT/GE/NV)
//   lt     in   effective less-than flag
//   ge     in   effective greater-or-equal flag
//   taken  out  1 when the branch resolves taken
module cond_eval
  import branch_pkg::*;
(
  input  br_cond_t cond,
  input  logic     lt,
  input  logic     ge,
  output logic     taken
);

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      BR_AL:   taken = 1'b1;
      BR_LT:   taken = lt;
      BR_GE:   taken = ge;
      BR_NV:   taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: latches compare flags from execute, resolves
// conditional branches from decode, redirects fetch and holds flush.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flag_we, flag_in     compare flag word ([0]=lt, [1]=ge) and its valid
//   br_valid/br_ready    branch request handshake from decode
//   br_cond, br_target   branch condition and destination
//   stall                decode must hold while waiting for flags
//   pc_sel, pc_target    one-cycle redirect to fetch
//   flush                squash fetch/decode, FLUSH_CYCLES cycles per taken branch
//   taken_cnt            taken-branch count (only with BRANCH_STATS_EN defined)
// Optional feature macro: BRANCH_STATS_EN.
module branch_unit
  import branch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 20,
  parameter int unsigned PC_WIDTH     = 20,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flag_we,
  input  logic [DATA_WIDTH-1:0] flag_in,
  input  logic                  br_valid,
  input  logic [1:0]            br_cond,
  input  logic [PC_WIDTH-1:0]   br_target,
  output logic                  br_ready,
  output logic                  stall,
  output logic                  pc_sel,
  output logic [PC_WIDTH-1:0]   pc_target,
  output logic                  flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]           taken_cnt
`endif
);

  localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_t           state_q, state_d;
  br_cond_t            cond_q, cond_d, eval_cond;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                lt_q, ge_q, flag_vld_q;
  logic                lt_eff, ge_eff, taken, enter_redirect;

  // Only the two low flag bits carry meaning.
  logic unused_flag_bits;
  assign unused_flag_bits = ^flag_in[DATA_WIDTH-1:2];

  // Same-cycle flag write bypasses the register.
  assign lt_eff = flag_we ? flag_in[FLAG_LT] : lt_q;
  assign ge_eff = flag_we ? flag_in[FLAG_GE] : ge_q;

  // IDLE resolves the incoming request; WAIT_FLAGS resolves the captured one.
  assign eval_cond = (state_q == IDLE) ? br_cond_t'(br_cond) : cond_q;

  cond_eval u_cond_eval (
    .cond  (eval_cond),
    .lt    (lt_eff),
    .ge    (ge_eff),
    .taken (taken)
  );

  always_comb begin
    state_d        = state_q;
    cond_d         = cond_q;
    target_d       = target_q;
    cnt_d          = cnt_q;
    enter_redirect = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (br_valid) begin
          cond_d   = br_cond_t'(br_cond);
          target_d = br_target;
          if (needs_flags(br_cond_t'(br_cond)) && !flag_vld_q && !flag_we) begin
            state_d = WAIT_FLAGS;
          end else if (taken) begin
            enter_redirect = 1'b1;
          end
        end
      end
      WAIT_FLAGS: begin
        if (flag_we) begin
          if (taken) enter_redirect = 1'b1;
          else       state_d        = IDLE;
        end
      end
      REDIRECT: begin
        state_d = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
      end
      FLUSH: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CntW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enter_redirect) begin
      state_d = REDIRECT;
      cnt_d   = CntW'(FLUSH_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cond_q     <= BR_AL;
      target_q   <= '0;
      cnt_q      <= '0;
      lt_q       <= 1'b0;
      ge_q       <= 1'b0;
      flag_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cond_q   <= cond_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      if (flag_we) begin
        lt_q       <= flag_in[FLAG_LT];
        ge_q       <= flag_in[FLAG_GE];
        flag_vld_q <= 1'b1;
      end
    end
  end

  // Outputs decode registered state only.
  assign br_ready  = (state_q == IDLE);
  assign stall     = (state_q == WAIT_FLAGS);
  assign pc_sel    = (state_q == REDIRECT);
  assign flush     = (state_q == REDIRECT) || (state_q == FLUSH);
  assign pc_target = (state_q == REDIRECT) ? target_q : '0;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              taken_cnt_q <= '0;
    else if (enter_redirect) taken_cnt_q <= taken_cnt_q + 16'd1;
  end

  assign taken_cnt = taken_cnt_q;
`endif

endmodule
